generic_sequence_detector: RTL and testbench

Runtime-programmable serial bit-pattern detector: the parametrised successor to the fixed-pattern Moore/Mealy detectors in the FSM sequence-detection library. It matches any pattern of 1..MAX_LEN bits and selects overlap/non-overlap and Moore/Mealy behaviour through configuration. It adds an input qualifier and a saturating match counter. It sits directly on a serial bitstream and replaces the per-pattern hard-coded FSM variants.

---
 rtl/seq_det_pkg.sv | 14 +
 rtl/generic_sequence_detector_counter.sv | 16 +
 rtl/generic_sequence_detector.sv | 73 +++++++
 tb/tb_generic_sequence_detector.sv | 102 ++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: mode constants and config record shared by sequence detectors
package seq_det_pkg;
  localparam logic OVERLAP     = 1'b1;
  localparam logic NON_OVERLAP = 1'b0;
  localparam logic MOORE       = 1'b1;
  localparam logic MEALY       = 1'b0;
  localparam int   CFG_MAX_LEN = 8;
  typedef struct packed {
    logic [CFG_MAX_LEN-1:0]         pattern;
    logic [$clog2(CFG_MAX_LEN):0]   len;
    logic                           overlap;
    logic                           moore;
  } seq_cfg_t;
endpackage

// File: rtl/generic_sequence_detector_counter.sv
// seq_match_counter: saturating match counter with synchronous clear
module seq_match_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q, count_d;
  // a hit coinciding with clear counts as the first match after the clear
  always_comb count_d = clr ? CNT_W'(inc) : (inc && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= rst ? '0 : count_d;
  assign count = count_q;
endmodule

// File: rtl/generic_sequence_detector.sv
// generic_sequence_detector: runtime-programmable serial pattern detector
module generic_sequence_detector
  import seq_det_pkg::*;
#(
  parameter int               MAX_LEN     = 8,
  parameter int               LEN_W       = $clog2(MAX_LEN) + 1,
  parameter int               CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0001_0101,
  parameter int               DEF_LEN     = 5,
  parameter logic             DEF_OVERLAP = 1'b1,
  parameter logic             DEF_MOORE   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_in,
  input  logic               valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  input  logic               count_clr,
  output logic               detected,
  output logic [CNT_W-1:0]   match_count
);
  logic [MAX_LEN-1:0] pattern_q, pattern_d, window, mask;
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [LEN_W-1:0]   len_q, len_d, len_eff, fill_q, fill_d;
  logic               overlap_q, overlap_d, moore_q, moore_d, moore_det_q, moore_det_d, hit;
  // the top history bit would only ever shift out, so it is not stored
  always_comb begin
    len_eff = (len_q > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len_q;
    window  = {hist_q, data_in};
    for (int i = 0; i < MAX_LEN; i++) mask[i] = LEN_W'(i) < len_eff;
    hit = valid && !cfg_we && len_eff != '0 && ({1'b0, fill_q} + 1'b1 >= {1'b0, len_eff})
          && ((window ^ pattern_q) & mask) == '0;
    pattern_d   = cfg_we ? cfg_pattern : pattern_q;
    len_d       = cfg_we ? cfg_len : len_q;
    overlap_d   = cfg_we ? cfg_overlap : overlap_q;
    moore_d     = cfg_we ? cfg_moore : moore_q;
    hist_d      = cfg_we ? '0 : valid ? window[MAX_LEN-2:0] : hist_q;
    fill_d      = cfg_we ? '0 : !valid ? fill_q : (hit && overlap_q == NON_OVERLAP) ? '0 :
                  (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
    moore_det_d = hit;
    detected    = (moore_q == MOORE) ? moore_det_q : hit;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_q   <= DEF_PATTERN;
      len_q       <= LEN_W'(DEF_LEN);
      overlap_q   <= DEF_OVERLAP;
      moore_q     <= DEF_MOORE;
      hist_q      <= '0;
      fill_q      <= '0;
      moore_det_q <= 1'b0;
    end else begin
      pattern_q   <= pattern_d;
      len_q       <= len_d;
      overlap_q   <= overlap_d;
      moore_q     <= moore_d;
      hist_q      <= hist_d;
      fill_q      <= fill_d;
      moore_det_q <= moore_det_d;
    end
  end
  seq_match_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (count_clr),
    .inc  (hit),
    .count(match_count)
  );
endmodule

// File: tb/tb_generic_sequence_detector.sv
// tb_generic_sequence_detector: directed scoreboard bench, 8-bit and 2-bit counter instances
module tb_generic_sequence_detector;
  logic       clk = 0, rst = 1, data_in = 0, valid = 0, cfg_we = 0, count_clr = 0;
  logic       cfg_overlap = 1, cfg_moore = 1;
  logic [7:0] cfg_pattern = 8'b0001_0101;
  logic [3:0] cfg_len = 4'd5;
  logic       detected, sat_det;
  logic [7:0] match_count;
  logic [1:0] sat_count;
  typedef struct {logic det; logic [7:0] cnt; int id;} exp_t;
  exp_t q[$];
  exp_t e;
  int   checks = 0, passed = 0, step_id = 0;

  always #5 clk = ~clk;

  generic_sequence_detector dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .count_clr(count_clr), .detected(detected), .match_count(match_count)
  );
  generic_sequence_detector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .valid(valid), .cfg_we(cfg_we),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .count_clr(count_clr), .detected(sat_det), .match_count(sat_count)
  );

  task automatic chk(input string n, input int id, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s step %0d: got %0d expected %0d", n, id, act, exp);
  endtask

  // expected outputs as seen mid-cycle: Mealy hit now, Moore/count from the previous edge
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("detected", e.id, int'(detected), int'(e.det));
      chk("match_count", e.id, int'(match_count), int'(e.cnt));
      chk("sat_detected", e.id, int'(sat_det), int'(e.det));
      chk("sat_count", e.id, int'(sat_count), (e.cnt > 3) ? 3 : int'(e.cnt));
    end
  end

  task automatic step(input logic r, v, d, we, clr, ed, input logic [7:0] ec);
    @(posedge clk);
    #1;
    rst = r; valid = v; data_in = d; cfg_we = we; count_clr = clr;
    step_id++;
    q.push_back('{ed, ec, step_id});
  endtask
  task automatic bit_in(input logic d, ed, input logic [7:0] ec);
    step(0, 1, d, 0, 0, ed, ec);
  endtask
  task automatic idle(input logic ed, input logic [7:0] ec);
    step(0, 0, 0, 0, 0, ed, ec);
  endtask
  task automatic set_cfg(input logic [7:0] p, input logic [3:0] l, input logic ov, mo);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_moore = mo;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    idle(0, 0);
    // defaults: 10101 overlap Moore
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
    bit_in(1, 0, 0); bit_in(0, 1, 1); bit_in(1, 0, 1); idle(1, 2); idle(0, 2);
    // non-overlap Mealy with counter clear
    set_cfg(8'b10101, 5, 0, 0); step(0, 0, 0, 1, 1, 0, 2);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
    bit_in(1, 1, 0); bit_in(0, 0, 1); bit_in(1, 0, 1); idle(0, 1);
    // 110 with idle cycles carrying a 0 that must not shift in
    set_cfg(8'b110, 3, 1, 0); step(0, 0, 0, 1, 0, 0, 1);
    bit_in(1, 0, 1); idle(0, 1); bit_in(1, 0, 1); idle(0, 1); idle(0, 1);
    bit_in(0, 1, 1); idle(0, 2);
    // len 1, overlap, Moore: saturation of the 2-bit counter, clear with hit
    set_cfg(8'b1, 1, 1, 1); step(0, 0, 0, 1, 1, 0, 2);
    bit_in(1, 0, 0); bit_in(1, 1, 1); bit_in(1, 1, 2); bit_in(1, 1, 3);
    bit_in(1, 1, 4); bit_in(1, 1, 5); bit_in(1, 1, 6); bit_in(1, 1, 7);
    step(0, 1, 1, 0, 1, 1, 8); idle(1, 1); idle(0, 1);
    // cfg_we one bit before completion discards that bit
    set_cfg(8'b10101, 5, 1, 0); step(0, 0, 0, 1, 1, 0, 1);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
    step(0, 1, 1, 1, 0, 0, 0);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
    bit_in(1, 1, 0); idle(0, 1);
    // reset mid-stream loses history and restores Moore defaults
    step(0, 0, 0, 1, 0, 0, 1);
    bit_in(1, 0, 1); bit_in(0, 0, 1); bit_in(1, 0, 1); bit_in(0, 0, 1);
    step(1, 0, 0, 0, 0, 0, 1);
    bit_in(1, 0, 0); bit_in(0, 0, 0); bit_in(1, 0, 0); bit_in(0, 0, 0);
    bit_in(1, 0, 0); idle(1, 1); idle(0, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
